adc_sample_capture: RTL and testbench

//  Consumer side of the stimulator's DO_SAMPLE strobe. Each DO_SAMPLE toggle requests one conversion.
//  The block reads one frame from a serial (SPI-style, mode 0) ADC and tags it with the sample index

---
 rtl/adc_sample_capture_if.sv | 11 +
 rtl/adc_sample_capture.sv | 108 ++++++++++
 tb/tb_adc_sample_capture.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_sample_capture_if.sv
// adc_sample_capture_if: serial ADC pins plus the tagged-sample valid/ready output stream
interface adc_sample_capture_if #(parameter int ADC_BITS = 12);
  logic ADC_SDO;
  logic ADC_CS_N;
  logic ADC_SCLK;
  logic [ADC_BITS+7:0] OUT_DATA;
  logic OUT_VALID;
  logic OUT_READY;
  modport master (input ADC_SDO, OUT_READY, output ADC_CS_N, ADC_SCLK, OUT_DATA, OUT_VALID);
  modport slave (output ADC_SDO, OUT_READY, input ADC_CS_N, ADC_SCLK, OUT_DATA, OUT_VALID);
endinterface

// File: rtl/adc_sample_capture.sv
// adc_sample_capture: per DO_SAMPLE edge, read one SPI ADC frame, tag it with the sample index, queue it
module adc_sample_capture #(
  parameter int ADC_BITS = 12,
  parameter int LEAD_BITS = 4,
  parameter int FIFO_DEPTH = 8
) (
  input logic CLK_500K,
  input logic RST,
  input logic DO_SAMPLE,
  input logic VSTIM_P,
  adc_sample_capture_if.master bus,
  output logic BUSY,
  output logic [7:0] MISS_CNT,
  output logic [7:0] OVF_CNT
);
  localparam int FRAME_BITS = LEAD_BITS + ADC_BITS;
  localparam int W = ADC_BITS + 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(2 * FRAME_BITS);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(2 * FRAME_BITS - 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, PUSH} state_t;
  state_t state;
  logic ds_q, vs_q, req, vs_rise;
  logic cs_n, sclk;
  logic [CW-1:0] cnt;
  logic [7:0] tag, sample_idx, miss_cnt, ovf_cnt;
  logic [ADC_BITS-1:0] shreg;
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop, full, wr, not_empty;
  assign req = DO_SAMPLE ^ ds_q;
  assign vs_rise = VSTIM_P & ~vs_q;
  assign push = state == PUSH;
  assign not_empty = count != '0;
  assign pop = bus.OUT_READY & not_empty;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign wr = push & (~full | pop);
  assign bus.ADC_CS_N = cs_n;
  assign bus.ADC_SCLK = sclk;
  assign bus.OUT_VALID = not_empty;
  assign bus.OUT_DATA = not_empty ? mem[rd_ptr] : '0;
  assign BUSY = state != IDLE;
  assign MISS_CNT = miss_cnt;
  assign OVF_CNT = ovf_cnt;
  // Input history always tracks the pins, so reset release never looks like an edge
  always_ff @(posedge CLK_500K) begin
    ds_q <= DO_SAMPLE;
    vs_q <= VSTIM_P;
  end
  // Conversion sequencer: select, clock out the frame, deselect, hand the tagged word to the FIFO
  always_ff @(posedge CLK_500K) begin
    if (RST) begin
      state <= IDLE;
      cs_n <= 1'b1;
      sclk <= 1'b0;
      cnt <= '0;
      tag <= '0;
      sample_idx <= '0;
      shreg <= '0;
      miss_cnt <= '0;
    end else begin
      if (req && state != IDLE && miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
      if (vs_rise) sample_idx <= '0;
      case (state)
        IDLE: if (req) begin
          state <= SETUP;
          cs_n <= 1'b0;
          tag <= vs_rise ? 8'd0 : sample_idx;
          sample_idx <= vs_rise ? 8'd1 : (sample_idx == 8'hFF ? 8'hFF : sample_idx + 8'd1);
        end
        SETUP: begin
          state <= SHIFT;
          cnt <= '0;
        end
        SHIFT: begin
          sclk <= ~cnt[0];
          if (!cnt[0]) shreg <= {shreg[ADC_BITS-2:0], bus.ADC_SDO};
          cnt <= cnt + CW'(1);
          if (cnt == SHIFT_LAST) state <= HOLD;
        end
        HOLD: begin
          state <= PUSH;
          cs_n <= 1'b1;
        end
        PUSH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // FIFO storage; the shift register holds only the last ADC_BITS samples, so lead bits fall off the top
  always_ff @(posedge CLK_500K)
    if (wr) mem[wr_ptr] <= {tag, shreg};
  // FIFO pointers, occupancy and overflow accounting; a pop frees the slot a full-FIFO push needs
  always_ff @(posedge CLK_500K) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf_cnt <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
      if (push && !wr && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_adc_sample_capture.sv
// tb_adc_sample_capture: table vectors, corner sequences and random traffic against a timing-level model
module tb_adc_sample_capture;
  logic CLK_500K = 1'b0;
  logic RST, DO_SAMPLE, VSTIM_P, BUSY;
  logic [7:0] MISS_CNT, OVF_CNT;
  adc_sample_capture_if #(.ADC_BITS(12)) bus();
  adc_sample_capture #(.ADC_BITS(12), .LEAD_BITS(4), .FIFO_DEPTH(8)) dut (
    .CLK_500K(CLK_500K), .RST(RST), .DO_SAMPLE(DO_SAMPLE), .VSTIM_P(VSTIM_P),
    .bus(bus.master), .BUSY(BUSY), .MISS_CNT(MISS_CNT), .OVF_CNT(OVF_CNT));
  always #5 CLK_500K = ~CLK_500K;
  int tests = 0, fails = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  logic [15:0] frame_src[$];
  logic [15:0] adc_q[$];
  logic [19:0] mq[$];
  logic [19:0] pend;
  int n = 0, bstart = -1000, m_idx = 0, m_miss = 0, m_ovf = 0, dut_pops = 0;
  bit started = 0;
  logic ds_prev, vs_prev;
  // ADC: a conversion occupies 36 edges from the accepting one; the word lands on edge +35
  always @(posedge CLK_500K) begin
    logic req, vr;
    logic [15:0] fr;
    n++;
    if (bus.OUT_VALID === 1'b1 && bus.OUT_READY) dut_pops++;
    if (RST) begin
      started = 1;
      mq.delete();
      adc_q.delete();
      bstart = -1000;
      m_idx = 0;
      m_miss = 0;
      m_ovf = 0;
    end else if (started) begin
      req = DO_SAMPLE != ds_prev;
      vr = VSTIM_P && !vs_prev;
      if (vr) m_idx = 0;
      if (bus.OUT_READY && mq.size() > 0) void'(mq.pop_front());
      if (n - bstart == 35) begin
        if (mq.size() < 8) mq.push_back(pend);
        else if (m_ovf < 255) m_ovf++;
      end
      if (req) begin
        if (n - bstart >= 36) begin
          bstart = n;
          if (frame_src.size() > 0) fr = frame_src.pop_front();
          else fr = 16'($urandom);
          adc_q.push_back(fr);
          pend = {8'(m_idx), fr[11:0]};
          if (m_idx < 255) m_idx++;
        end else if (m_miss < 255) m_miss++;
      end
    end
    ds_prev = DO_SAMPLE;
    vs_prev = VSTIM_P;
  end
  logic [15:0] cur;
  int bitn = 0;
  bit active = 0;
  // Mode-0 ADC: first bit on CS_N fall, next bit on each SCLK fall
  always @(negedge bus.ADC_CS_N or posedge bus.ADC_CS_N or negedge bus.ADC_SCLK)
    if (bus.ADC_CS_N !== 1'b0) active = 0;
    else if (!active) begin
      active = 1;
      bitn = 0;
      if (adc_q.size() > 0) cur = adc_q.pop_front();
      else cur = 16'h0;
      bus.ADC_SDO = cur[15];
    end else if (bitn < 15) begin
      bitn++;
      bus.ADC_SDO = cur[15-bitn];
    end
  // Every cycle: pins, status and FIFO head against the model
  always @(negedge CLK_500K)
    if (started) begin
      int d;
      logic [19:0] head;
      d = n - bstart;
      head = (mq.size() > 0) ? mq[0] : 20'h0;
      chk("cs_n", bus.ADC_CS_N, !(d >= 0 && d <= 33));
      chk("sclk", bus.ADC_SCLK, d >= 2 && d <= 32 && d % 2 == 0);
      chk("busy", BUSY, d >= 0 && d <= 34);
      chk("out_valid", bus.OUT_VALID, mq.size() > 0);
      chk("out_data", bus.OUT_DATA, head);
      chk("miss_cnt", MISS_CNT, m_miss);
      chk("ovf_cnt", OVF_CNT, m_ovf);
    end
  typedef struct {
    int vp;
    logic [3:0] lead;
    logic [11:0] data;
    logic [19:0] exp;
  } vec_t;
  vec_t vt[6];
  task automatic tick();
    @(posedge CLK_500K);
    #1;
  endtask
  task automatic pulse_rst();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask
  initial begin
    int lat, p0;
    vt[0] = '{0, 4'h0, 12'hA5C, 20'h00A5C};
    vt[1] = '{1, 4'hF, 12'h123, 20'h00123};
    vt[2] = '{0, 4'h5, 12'hFFF, 20'h01FFF};
    vt[3] = '{0, 4'hA, 12'h000, 20'h02000};
    vt[4] = '{2, 4'h3, 12'h5A5, 20'h005A5};
    vt[5] = '{0, 4'hC, 12'h801, 20'h01801};
    RST = 1'b1;
    DO_SAMPLE = 1'b0;
    VSTIM_P = 1'b0;
    bus.OUT_READY = 1'b1;
    bus.ADC_SDO = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    @(negedge CLK_500K);
    chk("rst_cs_n", bus.ADC_CS_N, 1);
    chk("rst_valid", bus.OUT_VALID, 0);
    chk("rst_data", bus.OUT_DATA, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      frame_src.push_back({vt[i].lead, vt[i].data});
      if (vt[i].vp == 1) begin
        VSTIM_P = 1'b1;
        tick();
        VSTIM_P = 1'b0;
        tick();
      end
      DO_SAMPLE = ~DO_SAMPLE;
      if (vt[i].vp == 2) VSTIM_P = 1'b1;
      tick();
      VSTIM_P = 1'b0;
      lat = 0;
      while (lat < 100) begin
        @(negedge CLK_500K);
        if (bus.OUT_VALID) break;
        @(posedge CLK_500K);
        lat++;
      end
      chk("vec_latency", lat, 35);
      chk("vec_data", bus.OUT_DATA, vt[i].exp);
      repeat (4) tick();
    end
    pulse_rst();
    p0 = dut_pops;
    for (int i = 0; i < 390; i++) begin
      DO_SAMPLE = ~DO_SAMPLE;
      tick();
    end
    repeat (45) tick();
    @(negedge CLK_500K);
    chk("burst_miss_sat", MISS_CNT, 255);
    chk("burst_conversions", dut_pops - p0, 11);
    tick();
    pulse_rst();
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      DO_SAMPLE = ~DO_SAMPLE;
      repeat (40) tick();
    end
    @(negedge CLK_500K);
    chk("full_ovf", OVF_CNT, 2);
    chk("full_valid", bus.OUT_VALID, 1);
    p0 = dut_pops;
    bus.OUT_READY = 1'b1;
    repeat (12) tick();
    @(negedge CLK_500K);
    chk("drain_count", dut_pops - p0, 8);
    chk("drain_empty", bus.OUT_VALID, 0);
    tick();
    RST = 1'b1;
    DO_SAMPLE = 1'b0;
    tick();
    RST = 1'b0;
    DO_SAMPLE = 1'b1;
    tick();
    repeat (10) tick();
    p0 = dut_pops;
    pulse_rst();
    @(negedge CLK_500K);
    chk("midrst_cs_n", bus.ADC_CS_N, 1);
    chk("midrst_sclk", bus.ADC_SCLK, 0);
    chk("midrst_busy", BUSY, 0);
    repeat (60) tick();
    @(negedge CLK_500K);
    chk("midrst_no_conv", dut_pops - p0, 0);
    chk("midrst_valid", bus.OUT_VALID, 0);
    tick();
    pulse_rst();
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      DO_SAMPLE = ~DO_SAMPLE;
      repeat (40) tick();
    end
    p0 = dut_pops;
    DO_SAMPLE = ~DO_SAMPLE;
    tick();
    repeat (34) @(posedge CLK_500K);
    #1 bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
    @(negedge CLK_500K);
    chk("pushpop_ovf", OVF_CNT, 0);
    chk("pushpop_valid", bus.OUT_VALID, 1);
    bus.OUT_READY = 1'b1;
    repeat (12) tick();
    @(negedge CLK_500K);
    chk("pushpop_total", dut_pops - p0, 9);
    tick();
    pulse_rst();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15) == 0) DO_SAMPLE = ~DO_SAMPLE;
      VSTIM_P = $urandom_range(49) == 0;
      bus.OUT_READY = $urandom_range(2) != 0;
      tick();
    end
    VSTIM_P = 1'b0;
    bus.OUT_READY = 1'b1;
    repeat (50) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
